crc_check: RTL

Receive-side counterpart of the write-path CRC generator: checks the write CRC on the DRAM-model side of the DDR5 PHY write path.
Per 8-bit lane, collects the 8 data beats of a burst, computes CRC-8 over the 64 collected bits and compares it with the CRC beat that follows.
Reports a per-lane error flag once per burst.
Used in the DRAM behavioural model and for PHY loopback self-check.

---
 rtl/crc_pkg.sv | 30 +++
 rtl/crc_chk_lane.sv | 34 +++
 rtl/crc_check.sv | 132 +++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared definitions for the DDR5 write-path CRC-8 checker (and generator).
//   CRC8_POLY       : x^8 + x^2 + x + 1, init 0x00, no reflection, no final XOR
//   BEATS_PER_BURST : data beats per burst (the CRC beat follows them)
//   crc_state_t     : checker FSM states
//   crc8_64         : CRC-8 over a 64-bit lane word, MSB (bit 63) shifted first
package crc_pkg;

  localparam logic [7:0] CRC8_POLY       = 8'h07;
  localparam int         BEATS_PER_BURST = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } crc_state_t;

  // Bit-serial LFSR unrolled over the whole lane word; synthesises to the
  // same XOR network the write-path generator uses.
  function automatic logic [7:0] crc8_64(input logic [63:0] data);
    logic [7:0] crc;
    logic       fb;
    crc = 8'h00;
    for (int i = 63; i >= 0; i--) begin
      fb  = crc[7] ^ data[i];
      crc = {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    end
    return crc;
  endfunction

endpackage

// File: rtl/crc_chk_lane.sv
// One 8-bit lane of the CRC checker.
//   clk, rst : clock, asynchronous active-high reset
//   shift    : shift the lane byte in as a data beat ({byte, reg[63:8]})
//   clear    : synchronous clear of the collected word (flush)
//   data     : this lane's byte of the current beat (data or CRC byte)
//   err      : combinational mismatch between CRC of the collected word and
//              data; only meaningful while the CRC beat is on the bus
module crc_chk_lane
  import crc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       shift,
  input  logic       clear,
  input  logic [7:0] data,
  output logic       err
);

  logic [63:0] sreg;

  // Beat 0 ends up in [7:0], beat 7 in [63:56], matching the generator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else if (clear) begin
      sreg <= '0;
    end else if (shift) begin
      sreg <= {data, sreg[63:8]};
    end
  end

  assign err = (crc8_64(sreg) != data);

endmodule

// File: rtl/crc_check.sv
// Receive-side write-CRC checker for the DDR5 PHY write path.
// Collects 8 data beats per lane, computes CRC-8 per lane and compares it
// with the CRC beat that follows; one result pulse per completed burst.
// Ports:
//   i_clk, i_reset  : clock, asynchronous active-high reset
//   i_rx_valid      : beat qualifier (no backpressure)
//   i_rx_data       : beat bus, lane j = bits [8j+7:8j]
//   i_flush         : synchronous abort of a partial burst (beats the valid)
//   o_err_valid     : one-cycle result pulse, cycle after the CRC beat
//   o_crc_err       : per-lane mismatch flags, held until the next result
//   o_crc_err_any   : OR of o_crc_err
//   o_busy          : burst partially received
// Optional (macro CRC_ERR_CNT_EN):
//   i_cnt_clr       : synchronous clear of the error counter (beats increment)
//   o_err_cnt       : saturating count of results with any lane in error
module crc_check
  import crc_pkg::*;
#(
  parameter  int N = 16,
  localparam int W = 2 * N,
  localparam int L = W / 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_rx_valid,
  input  logic [W-1:0] i_rx_data,
  input  logic         i_flush,
  output logic         o_err_valid,
  output logic [L-1:0] o_crc_err,
  output logic         o_crc_err_any,
  output logic         o_busy
`ifdef CRC_ERR_CNT_EN
  ,
  input  logic         i_cnt_clr,
  output logic [15:0]  o_err_cnt
`endif
);

  crc_state_t   state, state_nx;
  logic [3:0]   cnt, cnt_nx;
  logic         shift, clear, crc_beat;
  logic [L-1:0] lane_err;

  for (genvar j = 0; j < L; j++) begin : g_lane
    crc_chk_lane u_lane (
      .clk   (i_clk),
      .rst   (i_reset),
      .shift (shift),
      .clear (clear),
      .data  (i_rx_data[8*j +: 8]),
      .err   (lane_err[j])
    );
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shift    = 1'b0;
    clear    = 1'b0;
    crc_beat = 1'b0;
    if (i_flush) begin
      // Flush drops a coincident beat, including a CRC beat.
      state_nx = IDLE;
      cnt_nx   = '0;
      clear    = 1'b1;
    end else if (i_rx_valid) begin
      case (state)
        IDLE: begin
          state_nx = DATA;
          cnt_nx   = 4'd1;
          shift    = 1'b1;
        end
        DATA: begin
          shift  = 1'b1;
          cnt_nx = cnt + 4'd1;
          if (cnt == 4'(BEATS_PER_BURST - 1)) state_nx = CRC;
        end
        CRC: begin
          // Shift registers are left as-is; the next burst overwrites them.
          crc_beat = 1'b1;
          state_nx = IDLE;
          cnt_nx   = '0;
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // ---- result register stage: flags registered on the CRC-beat edge ----
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_err_valid   <= 1'b0;
      o_crc_err     <= '0;
      o_crc_err_any <= 1'b0;
    end else begin
      o_err_valid <= crc_beat;
      if (crc_beat) begin
        o_crc_err     <= lane_err;
        o_crc_err_any <= |lane_err;
      end
    end
  end

  assign o_busy = (state != IDLE);

`ifdef CRC_ERR_CNT_EN
  // Counts from the registered result, so it trails o_err_valid by a cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_err_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_err_cnt <= '0;
    end else if (o_err_valid && o_crc_err_any && (o_err_cnt != 16'hFFFF)) begin
      o_err_cnt <= o_err_cnt + 16'd1;
    end
  end
`endif

endmodule
